// File: rtl/anpc3l_multileg_comm_seq.sv
// NLEG independent 3-level ANPC commutation sequencers sharing one dead-time set.
// Each leg turns a Z/P/N level request into a timed six-switch gate sequence; a fault latches all gates off.
module anpc3l_multileg_comm_seq #(
   parameter int NLEG = 3,
   parameter int TW   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [TW-1:0]     t_short,
   input  logic [TW-1:0]     t_off_on,
   input  logic [TW-1:0]     t_on_offv0,
   input  logic [TW-1:0]     t_off_oni0,
   input  logic [2*NLEG-1:0] v_lev,
   input  logic [2*NLEG-1:0] comm_type,
   input  logic              fault,
   output logic [6*NLEG-1:0] s_out,
   output logic [NLEG-1:0]   busy,
   output logic [NLEG-1:0]   done,
   output logic [3*NLEG-1:0] state_o,
   output logic              faulted
);

   typedef enum logic [2:0] {
      ST_P   = 3'd0,
      ST_ZU2 = 3'd1,
      ST_ZU1 = 3'd2,
      ST_ZL1 = 3'd3,
      ST_ZL2 = 3'd4,
      ST_N   = 3'd5
   } leg_state_e;

   localparam logic [1:0] D_S = 2'd0;
   localparam logic [1:0] D_N = 2'd1;
   localparam logic [1:0] D_V = 2'd2;
   localparam logic [1:0] D_I = 2'd3;

   localparam logic [5:0] RESET_PAT = 6'b010010;

   // one step = {dwell select, gate pattern}; st[0] is applied on the start edge
   typedef struct packed {
      logic [2:0]      len;
      logic [3:0][7:0] st;
   } seq_t;

   typedef struct packed {
      logic       vld;
      leg_state_e tgt;
   } req_t;

   function automatic seq_t mk(input logic [2:0] len, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
      seq_t r;
      r.len   = len;
      r.st[0] = e0;
      r.st[1] = e1;
      r.st[2] = e2;
      r.st[3] = e3;
      return r;
   endfunction

   function automatic seq_t seq_lookup(input leg_state_e from, input leg_state_e to);
      seq_t r;
      case ({from, to})
         {ST_ZU2, ST_P}: r = mk(3'd3, {D_N, 6'b010000}, {D_S, 6'b110000}, {D_S, 6'b110001}, 8'h00);
         {ST_ZU2, ST_N}: r = mk(3'd3, {D_S, 6'b011010}, {D_N, 6'b001010}, {D_S, 6'b001110}, 8'h00);
         {ST_ZU1, ST_P}: r = mk(3'd4, {D_I, 6'b010010}, {D_S, 6'b010011}, {D_N, 6'b010001}, {D_S, 6'b110001});
         {ST_ZU1, ST_N}: r = mk(3'd2, {D_N, 6'b000110}, {D_S, 6'b001110}, 8'h00, 8'h00);
         {ST_ZL1, ST_P}: r = mk(3'd2, {D_N, 6'b100001}, {D_S, 6'b110001}, 8'h00, 8'h00);
         {ST_ZL1, ST_N}: r = mk(3'd4, {D_I, 6'b001001}, {D_S, 6'b001011}, {D_N, 6'b001010}, {D_S, 6'b001110});
         {ST_ZL2, ST_P}: r = mk(3'd3, {D_S, 6'b011001}, {D_N, 6'b010001}, {D_S, 6'b110001}, 8'h00);
         {ST_ZL2, ST_N}: r = mk(3'd3, {D_N, 6'b001000}, {D_S, 6'b001100}, {D_S, 6'b001110}, 8'h00);
         {ST_P, ST_ZU2}: r = mk(3'd3, {D_S, 6'b110000}, {D_N, 6'b010000}, {D_S, 6'b010010}, 8'h00);
         {ST_P, ST_ZU1}: r = mk(3'd4, {D_S, 6'b010001}, {D_N, 6'b010011}, {D_S, 6'b010010}, {D_S, 6'b010110});
         {ST_P, ST_ZL1}: r = mk(3'd2, {D_N, 6'b100001}, {D_S, 6'b101001}, 8'h00, 8'h00);
         {ST_P, ST_ZL2}: r = mk(3'd3, {D_N, 6'b010001}, {D_S, 6'b011001}, {D_S, 6'b001001}, 8'h00);
         {ST_N, ST_ZU2}: r = mk(3'd3, {D_N, 6'b001010}, {D_V, 6'b011010}, {D_S, 6'b010010}, 8'h00);
         {ST_N, ST_ZU1}: r = mk(3'd2, {D_N, 6'b000110}, {D_S, 6'b010110}, 8'h00, 8'h00);
         {ST_N, ST_ZL1}: r = mk(3'd4, {D_N, 6'b001010}, {D_S, 6'b001011}, {D_S, 6'b001001}, {D_S, 6'b101001});
         {ST_N, ST_ZL2}: r = mk(3'd3, {D_S, 6'b001100}, {D_N, 6'b001000}, {D_S, 6'b001001}, 8'h00);
         default:        r = mk(3'd1, {D_S, RESET_PAT}, 8'h00, 8'h00, 8'h00);
      endcase
      return r;
   endfunction

   function automatic logic [5:0] seq_pat(input leg_state_e from, input leg_state_e to, input logic [1:0] idx);
      seq_t s;
      s = seq_lookup(from, to);
      return s.st[idx][5:0];
   endfunction

   function automatic logic [1:0] seq_sel(input leg_state_e from, input leg_state_e to, input logic [1:0] idx);
      seq_t s;
      s = seq_lookup(from, to);
      return s.st[idx][7:6];
   endfunction

   function automatic logic seq_last(input leg_state_e from, input leg_state_e to, input logic [1:0] idx);
      seq_t s;
      s = seq_lookup(from, to);
      return ({1'b0, idx} == s.len - 3'd1);
   endfunction

   // last count value of a step; a zero dwell behaves as a single tick
   function automatic logic [TW-1:0] dwell_last(input logic [1:0] sel, input logic [TW-1:0] ts,
                                                input logic [TW-1:0] tn, input logic [TW-1:0] tv,
                                                input logic [TW-1:0] ti);
      logic [TW-1:0] t;
      case (sel)
         D_S:     t = ts;
         D_N:     t = tn;
         D_V:     t = tv;
         default: t = ti;
      endcase
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   function automatic req_t decode_req(input leg_state_e st, input logic [1:0] v, input logic [1:0] ct);
      req_t r;
      r.vld = 1'b0;
      r.tgt = st;
      case (st)
         ST_P: begin
            if (v == 2'd0) begin
               r.vld = 1'b1;
               case (ct)
                  2'd0:    r.tgt = ST_ZU2;
                  2'd1:    r.tgt = ST_ZU1;
                  2'd2:    r.tgt = ST_ZL2;
                  default: r.tgt = ST_ZL1;
               endcase
            end
         end
         ST_N: begin
            if (v == 2'd0) begin
               r.vld = 1'b1;
               case (ct)
                  2'd0:    r.tgt = ST_ZL2;
                  2'd1:    r.tgt = ST_ZL1;
                  2'd2:    r.tgt = ST_ZU2;
                  default: r.tgt = ST_ZU1;
               endcase
            end
         end
         default: begin
            if (v == 2'd1) begin
               r.vld = 1'b1;
               r.tgt = ST_P;
            end else if (v == 2'd2) begin
               r.vld = 1'b1;
               r.tgt = ST_N;
            end
         end
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         faulted <= 1'b0;
      end else if (fault) begin
         faulted <= 1'b1;
      end
   end

   for (genvar k = 0; k < NLEG; k++) begin : g_leg
      leg_state_e    state, state_nxt;
      leg_state_e    target, target_nxt;
      logic [1:0]    step, step_nxt;
      logic [TW-1:0] cnt, cnt_nxt;
      logic          busy_r, busy_nxt;
      logic          done_r, done_nxt;
      logic [5:0]    pat, pat_nxt;
      logic [TW-1:0] last_cnt;
      req_t          req;

      always_comb begin
         req        = decode_req(state, v_lev[2*k +: 2], comm_type[2*k +: 2]);
         last_cnt   = dwell_last(seq_sel(state, target, step), t_short, t_off_on, t_on_offv0, t_off_oni0);
         state_nxt  = state;
         target_nxt = target;
         step_nxt   = step;
         cnt_nxt    = cnt;
         busy_nxt   = busy_r;
         done_nxt   = 1'b0;
         pat_nxt    = pat;
         if (fault) begin
            pat_nxt  = '0;
            busy_nxt = 1'b0;
         end else if (ce && !faulted) begin
            if (busy_r) begin
               if (cnt >= last_cnt) begin
                  cnt_nxt = '0;
                  if (seq_last(state, target, step)) begin
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                     state_nxt = target;
                  end else begin
                     step_nxt = step + 2'd1;
                     pat_nxt  = seq_pat(state, target, step + 2'd1);
                  end
               end else begin
                  cnt_nxt = cnt + TW'(1);
               end
            end else if (req.vld) begin
               busy_nxt   = 1'b1;
               target_nxt = req.tgt;
               step_nxt   = '0;
               cnt_nxt    = '0;
               pat_nxt    = seq_pat(state, req.tgt, 2'd0);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state  <= ST_ZU2;
            target <= ST_ZU2;
            step   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pat    <= RESET_PAT;
         end else begin
            state  <= state_nxt;
            target <= target_nxt;
            step   <= step_nxt;
            cnt    <= cnt_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            pat    <= pat_nxt;
         end
      end

      assign s_out[6*k +: 6]   = pat;
      assign busy[k]           = busy_r;
      assign done[k]           = done_r;
      assign state_o[3*k +: 3] = state;
   end

endmodule
